// File: rtl/dev_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dev_bridge: CPU load/store initiator for the peripheral bus (3 devices +    |
// | PEND), with interrupt collection. Optional sticky pending: BRIDGE_IRQ_LATCH_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dev_bridge #(
   parameter logic [31:0] BASE = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [31:0] cpu_rdata,
   output logic        cpu_err,
   output logic [1:0]  dev_addr,
   output logic [31:0] dev_wdata,
   output logic [2:0]  dev_we,
   input  logic [31:0] dev_rdata0,
   input  logic [31:0] dev_rdata1,
   input  logic [31:0] dev_rdata2,
   input  logic [2:0]  dev_irq,
   output logic [5:0]  hwint
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        req_we;
   logic        req_win;
   logic [1:0]  req_sel;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        is_dev;
   logic        is_pend;
   logic        unmapped;
   logic [2:0]  pend_view;
   logic [31:0] read_mux;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr[1:0];

   // Decode is latched with the request; only the PEND word of slot 3 is mapped.
   assign is_dev   = req_win && (req_sel != 2'd3);
   assign is_pend  = req_win && (req_sel == 2'd3) && (dev_addr == 2'd0);
   assign unmapped = !(is_dev || is_pend);

`ifdef BRIDGE_IRQ_LATCH_EN
   logic [2:0] pend;
   logic [2:0] irq_prev;
   logic [2:0] pend_clr;

   assign pend_clr = (state == S_ACCESS && req_we && is_pend) ? dev_wdata[2:0] : 3'b000;

   // Rising-edge set is OR'd in after the clear so a simultaneous edge wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend     <= 3'b000;
         irq_prev <= 3'b000;
      end else begin
         irq_prev <= dev_irq;
         pend     <= (pend & ~pend_clr) | (dev_irq & ~irq_prev);
      end
   end

   assign pend_view = pend;
`else
   assign pend_view = dev_irq;
`endif

   assign hwint = {3'b000, pend_view};

   always_comb begin
      read_mux = 32'd0;
      if (req_win) begin
         case (req_sel)
            2'd0:    read_mux = dev_rdata0;
            2'd1:    read_mux = dev_rdata1;
            2'd2:    read_mux = dev_rdata2;
            default: read_mux = is_pend ? {29'd0, pend_view} : 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         req_we    <= 1'b0;
         req_win   <= 1'b0;
         req_sel   <= 2'd0;
         dev_addr  <= 2'd0;
         dev_wdata <= 32'd0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && cpu_req) begin
            req_we    <= cpu_we;
            req_win   <= (cpu_addr[31:6] == BASE[31:6]);
            req_sel   <= cpu_addr[5:4];
            dev_addr  <= cpu_addr[3:2];
            dev_wdata <= cpu_wdata;
         end
         if (state == S_ACCESS) begin
            rdata_q <= read_mux;
            err_q   <= unmapped;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      dev_we    = 3'b000;
      cpu_ack   = 1'b0;
      cpu_rdata = 32'd0;
      cpu_err   = 1'b0;
      case (state)
         S_IDLE: begin
            if (cpu_req) state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            state_nxt = S_RESP;
            // Strobe is suppressed during reset so an interrupted store never lands.
            if (req_we && is_dev && !reset) dev_we = 3'b001 << req_sel;
         end
         S_RESP: begin
            state_nxt = S_IDLE;
            cpu_ack   = 1'b1;
            cpu_err   = err_q;
            cpu_rdata = req_we ? 32'd0 : rdata_q;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dev_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dev_bridge: directed self-checking bench for dev_bridge                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dev_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic [1:0]  dev_addr;
   logic [31:0] dev_wdata;
   logic [2:0]  dev_we;
   logic [31:0] dev_rdata0;
   logic [31:0] dev_rdata1;
   logic [31:0] dev_rdata2;
   logic [2:0]  dev_irq;
   logic [5:0]  hwint;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2:0]  acc_we;
   logic [1:0]  acc_addr;
   logic [31:0] acc_wdata;
   logic        acc_ack;
   logic        resp_ack;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [2:0]  resp_we;
   logic [5:0]  resp_hwint;
   logic        idle_ack;
   logic [8:0]  ack_mask;

   dev_bridge dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata),
      .cpu_err    (cpu_err),
      .dev_addr   (dev_addr),
      .dev_wdata  (dev_wdata),
      .dev_we     (dev_we),
      .dev_rdata0 (dev_rdata0),
      .dev_rdata1 (dev_rdata1),
      .dev_rdata2 (dev_rdata2),
      .dev_irq    (dev_irq),
      .hwint      (hwint)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full transaction; samples ACCESS, RESP and the following IDLE cycle.
   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = wd;
      tick();
      cpu_req   = 1'b0;
      acc_we    = dev_we;
      acc_addr  = dev_addr;
      acc_wdata = dev_wdata;
      acc_ack   = cpu_ack;
      tick();
      resp_ack   = cpu_ack;
      resp_rdata = cpu_rdata;
      resp_err   = cpu_err;
      resp_we    = dev_we;
      resp_hwint = hwint;
      tick();
      idle_ack   = cpu_ack;
   endtask

   initial begin
      reset      = 1'b1;
      cpu_req    = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = 32'd0;
      cpu_wdata  = 32'd0;
      dev_rdata0 = 32'hA0A0_0000;
      dev_rdata1 = 32'h0000_0030;
      dev_rdata2 = 32'hC2C2_0002;
      dev_irq    = 3'b000;
      tick();
      tick();
      check("rst_ack",   {31'd0, cpu_ack}, 32'd0);
      check("rst_err",   {31'd0, cpu_err}, 32'd0);
      check("rst_rdata", cpu_rdata, 32'd0);
      check("rst_we",    {29'd0, dev_we}, 32'd0);
      check("rst_addr",  {30'd0, dev_addr}, 32'd0);
      check("rst_wdata", dev_wdata, 32'd0);
      check("rst_hwint", {26'd0, hwint}, 32'd0);
      reset = 1'b0;
      tick();

      // Store to timer0 word 1
      access(1'b1, 32'h0000_7F04, 32'h0000_0064);
      check("st0_acc_we",    {29'd0, acc_we}, 32'd1);
      check("st0_acc_addr",  {30'd0, acc_addr}, 32'd1);
      check("st0_acc_wdata", acc_wdata, 32'h64);
      check("st0_acc_ack",   {31'd0, acc_ack}, 32'd0);
      check("st0_resp_ack",  {31'd0, resp_ack}, 32'd1);
      check("st0_resp_err",  {31'd0, resp_err}, 32'd0);
      check("st0_resp_rd",   resp_rdata, 32'd0);
      check("st0_resp_we",   {29'd0, resp_we}, 32'd0);
      check("st0_idle_ack",  {31'd0, idle_ack}, 32'd0);
      check("st0_idle_we",   {29'd0, dev_we}, 32'd0);
      check("st0_hold_addr", {30'd0, dev_addr}, 32'd1);
      check("st0_hold_wd",   dev_wdata, 32'h64);

      // Load timer1 word 2
      access(1'b0, 32'h0000_7F18, 32'hFFFF_FFFF);
      check("ld1_acc_we",  {29'd0, acc_we}, 32'd0);
      check("ld1_acc_addr", {30'd0, acc_addr}, 32'd2);
      check("ld1_resp_we", {29'd0, resp_we}, 32'd0);
      check("ld1_ack",     {31'd0, resp_ack}, 32'd1);
      check("ld1_rdata",   resp_rdata, 32'h30);
      check("ld1_err",     {31'd0, resp_err}, 32'd0);

      // Device 2 load and store
      access(1'b0, 32'h0000_7F28, 32'd0);
      check("ld2_rdata", resp_rdata, 32'hC2C2_0002);
      access(1'b1, 32'h0000_7F2C, 32'h1234_5678);
      check("st2_acc_we",   {29'd0, acc_we}, 32'd4);
      check("st2_acc_addr", {30'd0, acc_addr}, 32'd3);
      check("st2_acc_wd",   acc_wdata, 32'h1234_5678);
      access(1'b0, 32'h0000_7F0C, 32'd0);
      check("ld0_rdata", resp_rdata, 32'hA0A0_0000);

      // Unmapped accesses
      access(1'b1, 32'h0000_7F38, 32'hDEAD_BEEF);
      check("um_st_we",  {29'd0, acc_we}, 32'd0);
      check("um_st_err", {31'd0, resp_err}, 32'd1);
      check("um_st_ack", {31'd0, resp_ack}, 32'd1);
      access(1'b0, 32'h0000_1000, 32'd0);
      check("um_ld_we",    {29'd0, acc_we}, 32'd0);
      check("um_ld_rdata", resp_rdata, 32'd0);
      check("um_ld_err",   {31'd0, resp_err}, 32'd1);
      access(1'b1, 32'h0000_8F04, 32'h5555_5555);
      check("um_win_we",  {29'd0, acc_we}, 32'd0);
      check("um_win_err", {31'd0, resp_err}, 32'd1);

      // Back-to-back: request held for 9 cycles
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h0000_7F00;
      ack_mask = 9'd0;
      ack_mask[0] = cpu_ack;
      for (int c = 1; c < 9; c++) begin
         tick();
         ack_mask[c] = cpu_ack;
      end
      cpu_req = 1'b0;
      tick();
      check("b2b_acks", {23'd0, ack_mask}, 32'h124);
      check("b2b_idle", {31'd0, cpu_ack}, 32'd0);

`ifdef BRIDGE_IRQ_LATCH_EN
      dev_irq = 3'b001;
      #1;
      check("irq_not_yet", {26'd0, hwint}, 32'd0);
      tick();
      check("irq_latched", {26'd0, hwint}, 32'd1);
      dev_irq = 3'b000;
      tick();
      check("irq_sticky", {26'd0, hwint}, 32'd1);
      access(1'b0, 32'h0000_7F30, 32'd0);
      check("pend_rd",  resp_rdata, 32'd1);
      check("pend_err", {31'd0, resp_err}, 32'd0);
      access(1'b1, 32'h0000_7F30, 32'd1);
      check("pend_clr_we",  {29'd0, acc_we}, 32'd0);
      check("pend_clr",     {26'd0, resp_hwint}, 32'd0);
      check("pend_clr_idle", {26'd0, hwint}, 32'd0);
      // Edge arrives on the same clock that applies the clear
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'h0000_7F30;
      cpu_wdata = 32'd1;
      tick();
      cpu_req = 1'b0;
      dev_irq = 3'b001;
      tick();
      check("set_wins_ack", {31'd0, cpu_ack}, 32'd1);
      check("set_wins",     {26'd0, hwint}, 32'd1);
      tick();
      dev_irq = 3'b000;
      tick();
      check("set_wins_hold", {26'd0, hwint}, 32'd1);
`else
      dev_irq = 3'b101;
      #1;
      check("irq_comb", {26'd0, hwint}, 32'h5);
      access(1'b0, 32'h0000_7F30, 32'd0);
      check("pend_rd",  resp_rdata, 32'h5);
      check("pend_err", {31'd0, resp_err}, 32'd0);
      access(1'b1, 32'h0000_7F30, 32'h7);
      check("pend_wr_we",  {29'd0, acc_we}, 32'd0);
      check("pend_wr_err", {31'd0, resp_err}, 32'd0);
      dev_irq = 3'b010;
      #1;
      check("irq_comb2", {26'd0, hwint}, 32'h2);
      dev_irq = 3'b000;
`endif

      // Reset during ACCESS of a store
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'h0000_7F08;
      cpu_wdata = 32'h0000_00AA;
      tick();
      cpu_req = 1'b0;
      check("rsta_pre_we", {29'd0, dev_we}, 32'd1);
      reset = 1'b1;
      #1;
      check("rsta_we_forced", {29'd0, dev_we}, 32'd0);
      tick();
      check("rsta_ack",   {31'd0, cpu_ack}, 32'd0);
      check("rsta_err",   {31'd0, cpu_err}, 32'd0);
      check("rsta_rdata", cpu_rdata, 32'd0);
      check("rsta_we",    {29'd0, dev_we}, 32'd0);
      check("rsta_addr",  {30'd0, dev_addr}, 32'd0);
      check("rsta_wdata", dev_wdata, 32'd0);
      check("rsta_hwint", {26'd0, hwint}, 32'd0);
      reset = 1'b0;
      tick();
      check("rsta_no_ack", {31'd0, cpu_ack}, 32'd0);
      tick();
      check("rsta_no_ack2", {31'd0, cpu_ack}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
